// File: rtl/scan_bridge_pkg.sv
// Shared widths, defaults and FSM encoding for the scan-chain to register-bus bridge.
package scan_bridge_pkg;

  localparam int unsigned ADDR_W             = 20;
  localparam int unsigned DATA_W             = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 12;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDone  = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/scan_sync.sv
// Multi-flop synchronizer for a single asynchronous level, async active-low reset.
module scan_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/scan_bus_bridge.sv
// Turns each toggle of the scan-side request token into one register-bus transaction
// using the statically scan-loaded cfg fields, and reports completion, read data and errors.
module scan_bus_bridge
  import scan_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_scan_id,
  input  logic              i_cfg_wen,
  input  logic              i_cfg_ren,
  input  logic [ADDR_W-1:0] i_cfg_addr,
  input  logic [DATA_W-1:0] i_cfg_wdata,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_ack,
  input  logic [DATA_W-1:0] i_bus_rdata,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_ready,
  output logic              o_err,
  output logic              o_busy
);

  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 4) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 4;
  localparam int unsigned ArmW = $clog2(SYNC_STAGES + 2);
  localparam logic [ArmW-1:0] ArmDone = ArmW'(SYNC_STAGES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  bridge_state_e r_state, w_state_nxt;

  logic              w_sync_id;
  logic              r_id_prev;
  logic [ArmW-1:0]   r_arm_cnt;
  logic              w_armed;
  logic              w_toggle;
  logic              w_valid_cmd;
  logic              w_timeout;
  logic              w_accept;
  logic              w_ack_hit;
  logic              w_to_hit;
  logic [CntW-1:0]   r_wait_cnt;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_ready;
  logic              r_err;

  scan_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_scan_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (i_scan_id),
    .o_q  (w_sync_id)
  );

  // Edge detection stays masked until the synchronizer and edge flop have
  // flushed the post-reset zeros, so a high token at release is not a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_prev <= 1'b0;
      r_arm_cnt <= '0;
    end else begin
      r_id_prev <= w_sync_id;
      if (!w_armed) begin
        r_arm_cnt <= r_arm_cnt + ArmW'(1);
      end
    end
  end

  assign w_armed     = (r_arm_cnt == ArmDone);
  assign w_toggle    = w_armed & (w_sync_id ^ r_id_prev);
  assign w_valid_cmd = i_cfg_wen | i_cfg_ren;
  assign w_timeout   = (r_wait_cnt == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_toggle) begin
          w_state_nxt = w_valid_cmd ? StIssue : StDone;
        end
      end
      StIssue: begin
        if (i_bus_ack || w_timeout) begin
          w_state_nxt = StDone;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    o_bus_req = 1'b0;
    o_busy    = 1'b1;
    w_accept  = 1'b0;
    w_ack_hit = 1'b0;
    w_to_hit  = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_busy   = 1'b0;
        w_accept = w_toggle;
      end
      StIssue: begin
        o_bus_req = 1'b1;
        w_ack_hit = i_bus_ack;
        // Ack wins over a timeout landing in the same cycle.
        w_to_hit  = ~i_bus_ack & w_timeout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt  <= '0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_rsp_rdata <= '0;
      r_rsp_ready <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_wait_cnt  <= '0;
      r_bus_we    <= i_cfg_wen;
      r_bus_addr  <= i_cfg_addr;
      r_bus_wdata <= i_cfg_wdata;
      r_rsp_ready <= 1'b0;
      r_err       <= ~w_valid_cmd;
    end else begin
      if (r_state == StIssue) begin
        r_wait_cnt <= r_wait_cnt + CntW'(1);
      end
      if (w_ack_hit) begin
        r_rsp_ready <= 1'b1;
        if (!r_bus_we) begin
          r_rsp_rdata <= i_bus_rdata;
        end
      end
      if (w_to_hit) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_ready = r_rsp_ready;
  assign o_err       = r_err;

endmodule

// File: doc/scan_bus_bridge.md
SCAN_BUS_BRIDGE -- requirements
Module: scan_bus_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 12: max cycles bus_req may wait for bus_ack.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on scan_id.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 scan_id  input  1  asynchronous request token; every toggle (0->1 or 1->0) is one request.
REQ-006 cfg_wen  input  1  write request from the scan-loaded chip registers; static while scan_id toggles.
REQ-007 cfg_ren  input  1  read request from the scan-loaded chip registers; static.
REQ-008 cfg_addr  input  20  target address from the scan-loaded chip registers; static.
REQ-009 cfg_wdata  input  32  write data from the scan-loaded chip registers; static.
REQ-010 bus_req  output  1  transaction request to the register/SRAM bus.
REQ-011 bus_we  output  1  1 = write, 0 = read; valid while bus_req=1.
REQ-012 bus_addr  output  20  address; valid while bus_req=1.
REQ-013 bus_wdata  output  32  write data; valid while bus_req=1.
REQ-014 bus_ack  input  1  transaction complete; sampled only while bus_req=1.
REQ-015 bus_rdata  input  32  read data; valid in the cycle bus_ack=1.
REQ-016 rsp_rdata  output  32  captured read data; captured into the scan chain rdata field on load_chain.
REQ-017 rsp_ready  output  1  last request completed; captured into the scan chain ready field on load_chain.
REQ-018 err  output  1  last request timed out or was malformed.
REQ-019 busy  output  1  FSM not in IDLE.

Function
REQ-020 FSM states: IDLE, ISSUE, DONE; IDLE->ISSUE on accepted toggle; ISSUE->DONE on bus_ack or timeout; DONE->IDLE unconditionally after one cycle.
REQ-021 The toggle is synchronized through SYNC_STAGES flops, then edge-detected against one further flop; with SYNC_STAGES=2, bus_req rises after the 3rd rising clk edge following the toggle.
REQ-022 On an accepted toggle, cfg_* are registered; bus_addr, bus_wdata and bus_we hold these values until the next accepted toggle.
REQ-023 On an accepted toggle, rsp_ready and err clear to 0; rsp_rdata holds its value.
REQ-024 cfg_wen=1 issues a write (bus_we=1), including when cfg_ren=1; cfg_ren=1 alone issues a read.
REQ-025 cfg_wen=cfg_ren=0 issues no bus_req; the FSM goes IDLE->DONE, sets err=1 and leaves rsp_ready=0.
REQ-026 bus_req stays 1 with stable fields through ISSUE and drops the cycle after bus_ack is sampled 1, including when bus_ack is already 1 on the first ISSUE cycle.
REQ-027 On a read ack, rsp_rdata <= bus_rdata and rsp_ready <= 1; on a write ack, rsp_ready <= 1 and rsp_rdata is unchanged.
REQ-028 A 4-bit (or wider) wait counter clears on entry to ISSUE; when it reaches TIMEOUT_CYCLES without ack, bus_req drops, err <= 1 and rsp_ready stays 0.
REQ-029 Toggles detected in ISSUE or DONE are dropped, never queued.
REQ-030 bus_ack while bus_req=0 is ignored.

Reset
REQ-031 rst_n low forces state to IDLE and bus_req, bus_we, rsp_ready, err, busy, counter and all synchronizer and edge flops to 0, and bus_addr, bus_wdata and rsp_rdata to 0, immediately and mid-transaction.
REQ-032 Edge detection is disarmed for SYNC_STAGES+1 cycles after rst_n deasserts, so scan_id=1 at release creates no request.

Structure
REQ-033 Package scan_bridge_pkg holds ADDR_W=20, DATA_W=32, the FSM state enum and the default TIMEOUT_CYCLES.
REQ-034 Sub-module scan_sync is a parameterized SYNC_STAGES flop synchronizer with async active-low reset; the edge detector, arming logic and FSM live in scan_bus_bridge.

Verification
REQ-035 Write test: cfg_wen=1, cfg_addr=0x00600, cfg_wdata=0x3, toggle scan_id, bus_ack 2 cycles after bus_req -> bus_we=1, bus_addr=0x00600, bus_wdata=0x3, rsp_ready=1, err=0.
REQ-036 Read test: cfg_ren=1, cfg_addr=0x00002, bus_ack on the first ISSUE cycle with bus_rdata=0x13579876 -> bus_req is high exactly 1 cycle, rsp_rdata=0x13579876, rsp_ready=1.
REQ-037 Timeout test: read of 0x001FF, bus_ack held 0 -> bus_req high exactly 12 cycles, err=1, rsp_ready=0, FSM returns to IDLE.
REQ-038 Overlap test: toggle scan_id again during ISSUE -> exactly one bus_req pulse; a later toggle in IDLE starts a new request.
REQ-039 Reset test: assert rst_n mid-ISSUE -> bus_req=0 and outputs 0 at once; release with scan_id=1 -> no bus_req for 20 cycles.
REQ-040 Malformed test: cfg_wen=cfg_ren=0 with a toggle -> no bus_req, err=1, rsp_ready=0; cfg_wen=cfg_ren=1 -> a write is issued.
